timer_irq_sequencer: RTL
========================

// Module: timer_irq_sequencer
// PURPOSE
//  Avalon-MM master that drives the s1 slave ports of the three-channel interval timer subsystem (16-bit data, 3-bit word address).
//  After reset it programs each timer to continuous mode with interrupts enabled.
//  It accepts runtime period/enable reconfiguration, services timer IRQs round-robin by clearing TO,
//  and emits one-clock tick pulses to the coil-drive sequencing logic.
// PARAMETERS
//  PERIOD0     32'd50000  reset-time tick interval of channel 0, in clocks (timer loaded with PERIODn-1)
//  PERIOD1     32'd50000  reset-time tick interval of channel 1, in clocks
//  PERIOD2     32'd50000  reset-time tick interval of channel 2, in clocks
// PORTS
//  timer_clk_clk        in   1   single clock; timers and this block share it
//  timer_reset_reset    in   1   asynchronous reset, active-high
//  timer_N_irq_irq      in   1   IRQ from timer N (N=0,1,2), level, active-high
//  timer_N_s1_address   out  3   word address to timer N
//  timer_N_s1_writedata out  16  write data to timer N
//  timer_N_s1_chipselect out 1   chip select to timer N
//  timer_N_s1_write_n   out  1   write strobe to timer N, active-low
//  cfg_valid            in   1   reconfiguration request
//  cfg_ready            out  1   block accepts a request this cycle
//  cfg_ch               in   2   target channel 0..2 (3 is ignored, handshake still completes)
//  cfg_period           in   32  tick interval in clocks; values <2 clamped to 2
//  cfg_en               in   1   1 = run with IRQ enabled, 0 = leave stopped
//  init_done            out  1   high once the reset-time programming completes; stays high
//  tick                 out  3   tick[N] one-clock pulse per serviced timer N timeout
// BEHAVIOUR
//  Timer register map: 0 STATUS (write any value clears TO); 1 CONTROL (b0 ITO, b1 CONT, b2 START, b3 STOP);
//   2 PERIODL; 3 PERIODH.
//  Reset values: all chipselect=0, write_n=1, address=0, writedata=0, tick=0, cfg_ready=0, init_done=0.
//  Bus write: exactly one clock with chipselect=1, write_n=0 on one channel only, then one gap clock with all chipselect=0.
//   A write therefore occupies 2 clocks. The block never reads; write_n is 1 whenever chipselect=0.
//  FSM states:
//   INIT: for ch 0,1,2 in order, write PERIODL=(PERIODn-1)[15:0], PERIODH=(PERIODn-1)[31:16], CONTROL=0x0007.
//    9 writes = 18 clocks. init_done rises on the clock after the last gap and the FSM enters IDLE.
//   IDLE: IRQ service has priority over cfg.
//    If any irq is high, go to SVC.
//    Otherwise cfg_ready=1; cfg_valid&cfg_ready captures the request, cfg_ready drops the next clock, and the FSM goes to CFG.
//   SVC: select the first asserted irq starting from rr_ptr+1 (mod 3), rr_ptr reset=2.
//    Write STATUS=0 to it; tick[ch]=1 during the write clock only; rr_ptr<=ch. After the gap clock, return to IDLE.
//    The gap clock guarantees the cleared irq is low before re-sampling.
//   CFG: write CONTROL=0x0008 (STOP), PERIODL, PERIODH of (clamped period-1), then STATUS=0.
//    Then write CONTROL=0x0007 if cfg_en, else 0x0000. That is 5 writes, 10 clocks, then IDLE.
//    cfg_ch=3 returns to IDLE without bus activity.
//    IRQs arriving during CFG wait, since they are level signals, and are serviced after.
//  cfg_ready=0 outside IDLE and during INIT. Requests are not queued, so the upstream holds cfg_valid.
//  Simultaneous irqs: each is served in turn, one service per 2-clock SVC, round-robin order, so no channel starves.
//  Reset mid-operation: outputs go immediately to reset values and INIT restarts from ch 0 after release.
//   A partially written timer is fully reprogrammed.
//  Period arithmetic: 32-bit unsigned. period-1 is computed after clamping, so no underflow.
// TESTING
//  Reset release, PERIOD0=100: 18 bus-clock INIT sequence. ch0 sees addr2=0x0063, addr3=0x0000, addr1=0x0007.
//   init_done=1 at clock 19.
//  irq0 asserted in IDLE: STATUS write to ch0 next clock, tick=3'b001 for exactly 1 clock, irq0 low by the gap.
//  irq0, irq1 and irq2 all high after init: service order ch0, ch1, ch2.
//   Tick pulses are 2 clocks apart, with no overlap on chipselects.
//  cfg_valid, ch=1, period=0x00012345, en=1: writes 0x0008, 0x2344, 0x0001, 0x0000, 0x0007 to ch1.
//   cfg_ready is low for 10 clocks.
//  cfg_period=0, en=0 on ch2: PERIODL=0x0001, PERIODH=0x0000, final CONTROL=0x0000. irq2 never asserts afterwards.
//  Reset asserted mid-CFG: chipselects drop the same clock. INIT replays in full. irq held high during INIT gets no tick until init_done.

Source files
------------

// File: rtl/timer_irq_sequencer_if.sv
// Avalon-MM write bus to the three interval timers plus the IRQ, reconfiguration and tick signals.
// Per-channel signals are packed arrays indexed by timer channel 0..2.
interface timer_irq_sequencer_if;
  logic [2:0]       irq;
  logic [2:0][2:0]  s1_address;
  logic [2:0][15:0] s1_writedata;
  logic [2:0]       s1_chipselect;
  logic [2:0]       s1_write_n;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_ch;
  logic [31:0]      cfg_period;
  logic             cfg_en;
  logic             init_done;
  logic [2:0]       tick;

  modport master (
    input  irq, cfg_valid, cfg_ch, cfg_period, cfg_en,
    output s1_address, s1_writedata, s1_chipselect, s1_write_n, cfg_ready, init_done, tick
  );

  modport slave (
    output irq, cfg_valid, cfg_ch, cfg_period, cfg_en,
    input  s1_address, s1_writedata, s1_chipselect, s1_write_n, cfg_ready, init_done, tick
  );
endinterface

// File: rtl/timer_irq_sequencer.sv
// Programs three interval timers after reset, applies runtime period/enable changes and
// services timer IRQs round-robin, pulsing tick[n] on each serviced timeout.
module timer_irq_sequencer #(
  parameter logic [31:0] PERIOD0 = 32'd50000,
  parameter logic [31:0] PERIOD1 = 32'd50000,
  parameter logic [31:0] PERIOD2 = 32'd50000
) (
  input logic                   timer_clk_clk,
  input logic                   timer_reset_reset,
  timer_irq_sequencer_if.master bus_io
);

  typedef enum logic [1:0] {StInit, StIdle, StSvc, StCfg} state_e;

  function automatic logic [31:0] load_of(input logic [31:0] p);
    return (p < 32'd2) ? 32'd1 : p - 32'd1;
  endfunction

  function automatic logic [1:0] next_ch(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       step_q, step_d;
  logic [1:0]       ch_q, ch_d;
  logic             phase_q, phase_d;
  logic [1:0]       rr_q, rr_d;
  logic [1:0]       cfg_ch_q, cfg_ch_d;
  logic [31:0]      cfg_load_q, cfg_load_d;
  logic             cfg_en_q, cfg_en_d;
  logic             init_done_q, init_done_d;
  logic [2:0]       tick_q, tick_d;
  logic [2:0]       cs_q, cs_d;
  logic [2:0][2:0]  addr_q, addr_d;
  logic [2:0][15:0] wdata_q, wdata_d;

  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [31:0] init_load;
  logic [1:0]  cand, pick;
  logic        found;

  // Bus outputs are registered so reset drives them idle and writes land one clock after decision.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    ch_d        = ch_q;
    phase_d     = phase_q;
    rr_d        = rr_q;
    cfg_ch_d    = cfg_ch_q;
    cfg_load_d  = cfg_load_q;
    cfg_en_d    = cfg_en_q;
    init_done_d = init_done_q;
    tick_d      = '0;
    wr_en       = 1'b0;
    wr_ch       = ch_q;
    wr_addr     = '0;
    wr_data     = '0;
    cand        = rr_q;
    pick        = rr_q;
    found       = 1'b0;

    case (ch_q)
      2'd0:    init_load = load_of(PERIOD0);
      2'd1:    init_load = load_of(PERIOD1);
      default: init_load = load_of(PERIOD2);
    endcase

    for (int k = 0; k < 3; k++) begin
      cand = next_ch(cand);
      if (!found && bus_io.irq[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end

    unique case (state_q)
      StInit: begin
        if (ch_q == 2'd3) begin
          init_done_d = 1'b1;
          state_d     = StIdle;
        end else if (!phase_q) begin
          wr_en   = 1'b1;
          phase_d = 1'b1;
          case (step_q)
            3'd0:    begin wr_addr = 3'd2; wr_data = init_load[15:0];  end
            3'd1:    begin wr_addr = 3'd3; wr_data = init_load[31:16]; end
            default: begin wr_addr = 3'd1; wr_data = 16'h0007;         end
          endcase
        end else begin
          phase_d = 1'b0;
          if (step_q == 3'd2) begin
            step_d = '0;
            ch_d   = ch_q + 2'd1;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
      end
      StIdle: begin
        if (found) begin
          wr_en        = 1'b1;
          wr_ch        = pick;
          tick_d[pick] = 1'b1;
          rr_d         = pick;
          state_d      = StSvc;
        end else if (bus_io.cfg_valid) begin
          cfg_ch_d   = bus_io.cfg_ch;
          cfg_load_d = load_of(bus_io.cfg_period);
          cfg_en_d   = bus_io.cfg_en;
          step_d     = '0;
          phase_d    = 1'b0;
          state_d    = StCfg;
        end
      end
      // The gap registered here keeps the cleared IRQ from being re-sampled high.
      StSvc: state_d = StIdle;
      StCfg: begin
        if (cfg_ch_q == 2'd3) begin
          state_d = StIdle;
        end else if (!phase_q) begin
          wr_en   = 1'b1;
          wr_ch   = cfg_ch_q;
          phase_d = 1'b1;
          case (step_q)
            3'd0:    begin wr_addr = 3'd1; wr_data = 16'h0008;          end
            3'd1:    begin wr_addr = 3'd2; wr_data = cfg_load_q[15:0];  end
            3'd2:    begin wr_addr = 3'd3; wr_data = cfg_load_q[31:16]; end
            3'd3:    begin wr_addr = 3'd0; wr_data = 16'h0000;          end
            default: begin wr_addr = 3'd1; wr_data = cfg_en_q ? 16'h0007 : 16'h0000; end
          endcase
        end else begin
          phase_d = 1'b0;
          if (step_q == 3'd4) state_d = StIdle;
          else                step_d  = step_q + 3'd1;
        end
      end
      default: state_d = StInit;
    endcase

    for (int n = 0; n < 3; n++) begin
      cs_d[n]    = wr_en && (wr_ch == 2'(n));
      addr_d[n]  = cs_d[n] ? wr_addr : 3'd0;
      wdata_d[n] = cs_d[n] ? wr_data : 16'h0000;
    end
  end

  always_ff @(posedge timer_clk_clk or posedge timer_reset_reset) begin
    if (timer_reset_reset) begin
      state_q     <= StInit;
      step_q      <= '0;
      ch_q        <= '0;
      phase_q     <= 1'b0;
      rr_q        <= 2'd2;
      cfg_ch_q    <= '0;
      cfg_load_q  <= '0;
      cfg_en_q    <= 1'b0;
      init_done_q <= 1'b0;
      tick_q      <= '0;
      cs_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      ch_q        <= ch_d;
      phase_q     <= phase_d;
      rr_q        <= rr_d;
      cfg_ch_q    <= cfg_ch_d;
      cfg_load_q  <= cfg_load_d;
      cfg_en_q    <= cfg_en_d;
      init_done_q <= init_done_d;
      tick_q      <= tick_d;
      cs_q        <= cs_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign bus_io.s1_chipselect = cs_q;
  assign bus_io.s1_write_n    = ~cs_q;
  assign bus_io.s1_address    = addr_q;
  assign bus_io.s1_writedata  = wdata_q;
  assign bus_io.tick          = tick_q;
  assign bus_io.init_done     = init_done_q;
  assign bus_io.cfg_ready     = (state_q == StIdle) && !(|bus_io.irq);

endmodule
